// File: rtl/pid_pkg.sv
// Shared definitions for the PID start/wait/complete sequencer.
// Holds the one-hot sequencer state encoding, default widths and
// timeout, the axis index constants and the per-axis completion test.
package pid_pkg;

  localparam int DEFAULT_RATE_WIDTH     = 16;
  localparam int DEFAULT_TIMEOUT_CYCLES = 32;

  localparam int NUM_AXES = 3;
  localparam int ROLL     = 0;
  localparam int PITCH    = 1;
  localparam int YAW      = 2;

  // One-hot so every decoded output is a single state bit.
  typedef enum logic [4:0] {
    IDLE      = 5'b00001,
    START     = 5'b00010,
    WAIT_DONE = 5'b00100,
    RELEASE   = 5'b01000,
    ABORT     = 5'b10000
  } seq_state_e;

  // A PID that is idle also reports complete; only active && complete
  // means a fresh result is on rate_out.
  function automatic logic axisComplete(input logic active, input logic complete);
    return active && complete;
  endfunction

endpackage

// File: rtl/pid_sequencer_if.sv
// Bundle of the loop trigger, the three PID handshakes and the rate
// triple delivered to the motor mixer.
//   master : the sequencer (drives start/wait flags, latched rates, status)
//   slave  : the environment (IMU trigger, PIDs, mixer)
interface pid_sequencer_if
  import pid_pkg::*;
#(
  parameter int PID_RATE_BIT_WIDTH = DEFAULT_RATE_WIDTH
);

  logic                          trigger;
  logic [NUM_AXES-1:0]           pid_active;
  logic [NUM_AXES-1:0]           pid_complete;
  logic [PID_RATE_BIT_WIDTH-1:0] roll_rate_in;
  logic [PID_RATE_BIT_WIDTH-1:0] pitch_rate_in;
  logic [PID_RATE_BIT_WIDTH-1:0] yaw_rate_in;

  logic                          start_flag;
  logic                          wait_flag;
  logic [PID_RATE_BIT_WIDTH-1:0] roll_rate;
  logic [PID_RATE_BIT_WIDTH-1:0] pitch_rate;
  logic [PID_RATE_BIT_WIDTH-1:0] yaw_rate;
  logic                          rates_valid;
  logic                          busy;
  logic                          timeout_err;
  logic                          overrun_err;

  modport master (
    input  trigger, pid_active, pid_complete,
           roll_rate_in, pitch_rate_in, yaw_rate_in,
    output start_flag, wait_flag, roll_rate, pitch_rate, yaw_rate,
           rates_valid, busy, timeout_err, overrun_err
  );

  modport slave (
    output trigger, pid_active, pid_complete,
           roll_rate_in, pitch_rate_in, yaw_rate_in,
    input  start_flag, wait_flag, roll_rate, pitch_rate, yaw_rate,
           rates_valid, busy, timeout_err, overrun_err
  );

endinterface

// File: rtl/pid_axis_capture.sv
// Per-axis result capture for the PID sequencer.
// Ports:
//   us_clk, resetn : clock, async active-low reset
//   clear_i        : drops the done bit (sequencer idle)
//   enable_i       : capture window (sequencer waiting for completion)
//   active_i       : PID pid_active
//   complete_i     : PID pid_complete
//   rate_i         : PID rate_out
//   done_o         : this axis already captured in the current run
//   capture_o      : capture happening this cycle
//   rate_o         : latched rate
module pid_axis_capture
  import pid_pkg::*;
#(
  parameter int RATE_W = DEFAULT_RATE_WIDTH
) (
  input  logic              us_clk,
  input  logic              resetn,
  input  logic              clear_i,
  input  logic              enable_i,
  input  logic              active_i,
  input  logic              complete_i,
  input  logic [RATE_W-1:0] rate_i,
  output logic              done_o,
  output logic              capture_o,
  output logic [RATE_W-1:0] rate_o
);

  logic              done_q;
  logic [RATE_W-1:0] rate_q;

  // Only the first complete cycle captures; done_q blocks recapture so a
  // PID changing rate_out while it holds complete cannot corrupt the triple.
  assign capture_o = enable_i && !done_q && axisComplete(active_i, complete_i);
  assign done_o    = done_q;
  assign rate_o    = rate_q;

  // Done bit and latched rate. The latched rate is only ever overwritten
  // by a capture, so an aborted run leaves the previous result in place.
  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      done_q <= 1'b0;
      rate_q <= '0;
    end else begin
      if (clear_i) begin
        done_q <= 1'b0;
      end else if (capture_o) begin
        done_q <= 1'b1;
      end
      if (capture_o) begin
        rate_q <= rate_i;
      end
    end
  end

endmodule

// File: rtl/pid_sequencer.sv
// Initiator side of the roll/pitch/yaw PID start/wait/complete handshake.
// On each accepted trigger it starts all three PIDs, captures each rate
// as its PID completes, releases the PIDs and pulses rates_valid once
// with the new triple. Timeouts guard both the wait and the release.
// Ports:
//   us_clk, resetn : 1 MHz clock, async active-low reset
//   bus            : pid_sequencer_if master (trigger, PID handshakes,
//                    rates in/out, rates_valid, busy, error flags)
module pid_sequencer
  import pid_pkg::*;
#(
  parameter int PID_RATE_BIT_WIDTH = DEFAULT_RATE_WIDTH,
  parameter int TIMEOUT_CYCLES     = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic            us_clk,
  input  logic            resetn,
  pid_sequencer_if.master bus
);

  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cntInc;
  logic             timeoutErr_q, timeoutErr_d;
  logic             overrunErr_q, overrunErr_d;
  logic             startFlag_q, waitFlag_q, busy_q, ratesValid_q;
  logic             timeoutHit, allDone;

  logic [NUM_AXES-1:0]                         doneVec, capVec;
  logic [NUM_AXES-1:0][PID_RATE_BIT_WIDTH-1:0] rateIn, rateOut;

  assign rateIn[ROLL]  = bus.roll_rate_in;
  assign rateIn[PITCH] = bus.pitch_rate_in;
  assign rateIn[YAW]   = bus.yaw_rate_in;

  for (genvar i = 0; i < NUM_AXES; i++) begin : gAxis
    pid_axis_capture #(
      .RATE_W (PID_RATE_BIT_WIDTH)
    ) uCapture (
      .us_clk     (us_clk),
      .resetn     (resetn),
      .clear_i    (state_q == IDLE),
      .enable_i   (state_q == WAIT_DONE),
      .active_i   (bus.pid_active[i]),
      .complete_i (bus.pid_complete[i]),
      .rate_i     (rateIn[i]),
      .done_o     (doneVec[i]),
      .capture_o  (capVec[i]),
      .rate_o     (rateOut[i])
    );
  end

  // An axis captured this very cycle already counts towards completion.
  assign allDone    = &(doneVec | capVec);
  // The counter holds the number of whole cycles already spent in the
  // current guarded state, so this fires at the end of the last allowed one.
  assign timeoutHit = (cnt_q >= CNT_LAST);
  assign cntInc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  // Next-state logic. Timeout is tested before completion so a late
  // completion on the final cycle still aborts.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    timeoutErr_d = timeoutErr_q;
    overrunErr_d = overrunErr_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.trigger) begin
          state_d      = START;
          timeoutErr_d = 1'b0;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        cnt_d = cntInc;
        if (timeoutHit) begin
          state_d      = ABORT;
          timeoutErr_d = 1'b1;
          cnt_d        = '0;
        end else if (allDone) begin
          state_d = RELEASE;
          cnt_d   = '0;
        end
      end
      RELEASE, ABORT: begin
        cnt_d = cntInc;
        if (timeoutHit) begin
          state_d      = IDLE;
          timeoutErr_d = 1'b1;
        end else if (bus.pid_active == '0) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    // Any trigger outside IDLE, including the cycle that returns to IDLE,
    // is dropped and flagged.
    if (bus.trigger && (state_q != IDLE)) begin
      overrunErr_d = 1'b1;
    end
  end

  // Sequencer registers. The flag outputs are registered copies of the
  // decoded next state so they line up exactly with state_q.
  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      timeoutErr_q <= 1'b0;
      overrunErr_q <= 1'b0;
      startFlag_q  <= 1'b0;
      waitFlag_q   <= 1'b0;
      busy_q       <= 1'b0;
      ratesValid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      timeoutErr_q <= timeoutErr_d;
      overrunErr_q <= overrunErr_d;
      startFlag_q  <= (state_d == START);
      waitFlag_q   <= (state_d == RELEASE) || (state_d == ABORT);
      busy_q       <= (state_d != IDLE);
      ratesValid_q <= (state_q == WAIT_DONE) && (state_d == RELEASE);
    end
  end

  assign bus.start_flag  = startFlag_q;
  assign bus.wait_flag   = waitFlag_q;
  assign bus.busy        = busy_q;
  assign bus.rates_valid = ratesValid_q;
  assign bus.timeout_err = timeoutErr_q;
  assign bus.overrun_err = overrunErr_q;
  assign bus.roll_rate   = rateOut[ROLL];
  assign bus.pitch_rate  = rateOut[PITCH];
  assign bus.yaw_rate    = rateOut[YAW];

endmodule

// File: tb/tb_pid_sequencer.sv
// Testbench for pid_sequencer: behavioural PID models answer the
// start/wait handshake; expected rate triples go into a scoreboard queue
// and a monitor pops one on every rates_valid pulse.
module tb_pid_sequencer;

  typedef struct packed {
    logic [15:0] r;
    logic [15:0] p;
    logic [15:0] y;
  } rates_t;

  logic us_clk = 1'b0;
  logic resetn;

  pid_sequencer_if #(.PID_RATE_BIT_WIDTH(16)) bus ();

  pid_sequencer #(
    .PID_RATE_BIT_WIDTH (16),
    .TIMEOUT_CYCLES     (32)
  ) dut (
    .us_clk (us_clk),
    .resetn (resetn),
    .bus    (bus.master)
  );

  always #5 us_clk = ~us_clk;

  int     vecCount;
  int     missCount;
  rates_t expQ[$];

  // PID model state, one entry per axis
  logic        act[3];
  logic        cmp[3];
  logic        waitSeen[3];
  logic        stale[3];
  logic        stuck[3];
  int          cnt[3];
  int          lat[3];
  logic [15:0] rateVal[3];

  // Compare one value and report a miss
  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic driveBus();
    bus.pid_active    = {act[2], act[1], act[0]};
    bus.pid_complete  = {cmp[2], cmp[1], cmp[0]};
    bus.roll_rate_in  = rateVal[0];
    bus.pitch_rate_in = rateVal[1];
    bus.yaw_rate_in   = rateVal[2];
  endtask

  task automatic resetModel();
    for (int i = 0; i < 3; i++) begin
      act[i] = 1'b0; cmp[i] = 1'b0; waitSeen[i] = 1'b0;
      stale[i] = 1'b0; stuck[i] = 1'b0; cnt[i] = 0; lat[i] = 5;
    end
    driveBus();
  endtask

  // Advance one clock; the PID models react to the flags seen during the
  // cycle that just ended. Ends #1 after the rising edge.
  task automatic applyStimulus();
    logic startS, waitS;
    @(negedge us_clk);
    startS = bus.start_flag;
    waitS  = bus.wait_flag;
    @(posedge us_clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      if (!resetn) begin
        act[i] = 1'b0; cmp[i] = 1'b0; waitSeen[i] = 1'b0;
      end else if (stale[i]) begin
        act[i] = 1'b0; cmp[i] = 1'b1;
      end else if (!act[i]) begin
        if (startS) begin
          act[i] = 1'b1; cmp[i] = 1'b0; cnt[i] = 0; waitSeen[i] = 1'b0;
        end
      end else begin
        if (!cmp[i]) begin
          cnt[i]++;
          if (cnt[i] == lat[i]) cmp[i] = 1'b1;
        end
        if (waitS && !stuck[i]) begin
          if (waitSeen[i]) begin
            act[i] = 1'b0; cmp[i] = 1'b0;
          end else begin
            waitSeen[i] = 1'b1;
          end
        end
      end
    end
    driveBus();
  endtask

  task automatic setRates(input logic [15:0] r, input logic [15:0] p, input logic [15:0] y);
    rateVal[0] = r; rateVal[1] = p; rateVal[2] = y;
    driveBus();
  endtask

  task automatic fireTrigger();
    bus.trigger = 1'b1;
    applyStimulus();
    bus.trigger = 1'b0;
  endtask

  // Full nominal run from IDLE; extra triggers are sampled at edges trigA/trigB
  task automatic runNominal(input string tag, input logic [15:0] r, input logic [15:0] p,
                            input logic [15:0] y, input int trigA, input int trigB);
    setRates(r, p, y);
    expQ.push_back('{r: r, p: p, y: y});
    fireTrigger();
    checkOutput({tag, "_start_T0"}, 32'(bus.start_flag), 32'd1);
    checkOutput({tag, "_busy_T0"}, 32'(bus.busy), 32'd1);
    checkOutput({tag, "_tmo_clr_T0"}, 32'(bus.timeout_err), 32'd0);
    for (int t = 1; t <= 10; t++) begin
      bus.trigger = (t == trigA) || (t == trigB);
      applyStimulus();
      bus.trigger = 1'b0;
      checkOutput($sformatf("%s_start_T%0d", tag, t), 32'(bus.start_flag), 32'd0);
      checkOutput($sformatf("%s_valid_T%0d", tag, t), 32'(bus.rates_valid), 32'(t == 7));
      checkOutput($sformatf("%s_wait_T%0d", tag, t), 32'(bus.wait_flag), 32'(t >= 7 && t <= 9));
      checkOutput($sformatf("%s_busy_T%0d", tag, t), 32'(bus.busy), 32'(t <= 9));
    end
  endtask

  // Scoreboard monitor: one expected triple per rates_valid pulse
  always @(negedge us_clk) begin
    rates_t e;
    if (resetn && bus.rates_valid) begin
      if (expQ.size() == 0) begin
        vecCount++;
        missCount++;
        $display("[TB] FAIL sb_unexpected: rates_valid with %h/%h/%h, required no pulse",
                 bus.roll_rate, bus.pitch_rate, bus.yaw_rate);
      end else begin
        e = expQ.pop_front();
        checkOutput("sb_roll", 32'(bus.roll_rate), 32'(e.r));
        checkOutput("sb_pitch", 32'(bus.pitch_rate), 32'(e.p));
        checkOutput("sb_yaw", 32'(bus.yaw_rate), 32'(e.y));
      end
    end
  end

  initial begin
    vecCount    = 0;
    missCount   = 0;
    resetn      = 1'b0;
    bus.trigger = 1'b0;
    for (int i = 0; i < 3; i++) rateVal[i] = '0;
    resetModel();

    // Reset values
    #12;
    checkOutput("rst_start", 32'(bus.start_flag), 32'd0);
    checkOutput("rst_wait", 32'(bus.wait_flag), 32'd0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_valid", 32'(bus.rates_valid), 32'd0);
    checkOutput("rst_rates", {16'h0, bus.roll_rate | bus.pitch_rate | bus.yaw_rate}, 32'd0);
    checkOutput("rst_errs", 32'({bus.timeout_err, bus.overrun_err}), 32'd0);
    @(posedge us_clk);
    #1;
    resetn = 1'b1;
    applyStimulus();
    applyStimulus();
    checkOutput("idle_busy", 32'(bus.busy), 32'd0);

    // 1. Nominal run
    $display("[TB] nominal run");
    runNominal("nom", 16'h0123, 16'hFF00, 16'h7FFF, -1, -1);
    checkOutput("nom_overrun", 32'(bus.overrun_err), 32'd0);

    // 2. Staggered completion: yaw five cycles late, roll rate_in changes afterwards
    $display("[TB] staggered completion");
    setRates(16'h1111, 16'h8000, 16'h0042);
    lat[2] = 10;
    expQ.push_back('{r: 16'h1111, p: 16'h8000, y: 16'h0042});
    fireTrigger();
    for (int t = 1; t <= 15; t++) begin
      applyStimulus();
      if (t == 8) setRates(16'hABCD, 16'h8000, 16'h0042);
      if (t == 11) checkOutput("stag_valid_T11", 32'(bus.rates_valid), 32'd0);
      if (t == 12) checkOutput("stag_valid_T12", 32'(bus.rates_valid), 32'd1);
      if (t == 12) checkOutput("stag_wait_T12", 32'(bus.wait_flag), 32'd1);
      if (t == 14) checkOutput("stag_busy_T14", 32'(bus.busy), 32'd1);
      if (t == 15) checkOutput("stag_busy_T15", 32'(bus.busy), 32'd0);
    end
    checkOutput("stag_roll_held", 32'(bus.roll_rate), 32'h1111);
    resetModel();

    // 3. Stale complete: complete without active never counts
    $display("[TB] stale complete");
    for (int i = 0; i < 3; i++) stale[i] = 1'b1;
    setRates(16'hDEAD, 16'hBEEF, 16'hCAFE);
    fireTrigger();
    for (int t = 1; t <= 34; t++) begin
      applyStimulus();
      if (t == 32) begin
        checkOutput("stale_busy_T32", 32'(bus.busy), 32'd1);
        checkOutput("stale_tmo_T32", 32'(bus.timeout_err), 32'd0);
        checkOutput("stale_wait_T32", 32'(bus.wait_flag), 32'd0);
      end
      if (t == 33) begin
        checkOutput("stale_tmo_T33", 32'(bus.timeout_err), 32'd1);
        checkOutput("stale_wait_T33", 32'(bus.wait_flag), 32'd1);
      end
      if (t == 34) begin
        checkOutput("stale_busy_T34", 32'(bus.busy), 32'd0);
        checkOutput("stale_tmo_T34", 32'(bus.timeout_err), 32'd1);
      end
    end
    checkOutput("stale_roll", 32'(bus.roll_rate), 32'h1111);
    checkOutput("stale_pitch", 32'(bus.pitch_rate), 32'h8000);
    checkOutput("stale_yaw", 32'(bus.yaw_rate), 32'h0042);
    resetModel();
    applyStimulus();

    // 4. Overrun: triggers at T3 and T8 are dropped
    $display("[TB] overrun");
    runNominal("ovr", 16'h0A0A, 16'hF0F0, 16'h0001, 3, 8);
    checkOutput("ovr_overrun", 32'(bus.overrun_err), 32'd1);
    checkOutput("ovr_tmo", 32'(bus.timeout_err), 32'd0);

    // 5. Reset mid-run
    $display("[TB] reset mid-run");
    setRates(16'h2222, 16'h3333, 16'h4444);
    fireTrigger();
    for (int t = 1; t <= 5; t++) applyStimulus();
    resetn = 1'b0;
    #2;
    checkOutput("mrst_start", 32'(bus.start_flag), 32'd0);
    checkOutput("mrst_wait", 32'(bus.wait_flag), 32'd0);
    checkOutput("mrst_busy", 32'(bus.busy), 32'd0);
    checkOutput("mrst_rates", {16'h0, bus.roll_rate | bus.pitch_rate | bus.yaw_rate}, 32'd0);
    checkOutput("mrst_overrun", 32'(bus.overrun_err), 32'd0);
    resetModel();
    applyStimulus();
    applyStimulus();
    resetn = 1'b1;
    applyStimulus();
    runNominal("mrst2", 16'h5555, 16'hAAAA, 16'h0F0F, -1, -1);

    // 6. Yaw PID stuck active after wait_flag
    $display("[TB] stuck in release");
    setRates(16'h1234, 16'h8765, 16'h00FF);
    stuck[2] = 1'b1;
    expQ.push_back('{r: 16'h1234, p: 16'h8765, y: 16'h00FF});
    fireTrigger();
    for (int t = 1; t <= 39; t++) begin
      applyStimulus();
      if (t == 7) checkOutput("stuck_valid_T7", 32'(bus.rates_valid), 32'd1);
      if (t == 38) begin
        checkOutput("stuck_busy_T38", 32'(bus.busy), 32'd1);
        checkOutput("stuck_tmo_T38", 32'(bus.timeout_err), 32'd0);
        checkOutput("stuck_wait_T38", 32'(bus.wait_flag), 32'd1);
      end
      if (t == 39) begin
        checkOutput("stuck_busy_T39", 32'(bus.busy), 32'd0);
        checkOutput("stuck_tmo_T39", 32'(bus.timeout_err), 32'd1);
        checkOutput("stuck_wait_T39", 32'(bus.wait_flag), 32'd0);
      end
    end
    checkOutput("stuck_yaw_held", 32'(bus.yaw_rate), 32'h00FF);
    resetModel();
    applyStimulus();
    runNominal("post", 16'h0BAD, 16'h0DAD, 16'h0FAD, -1, -1);

    applyStimulus();
    checkOutput("sb_drained", 32'(expQ.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
